// File: rtl/hamming_pkg.sv
// Shared types and the (13,8) SECDED encoder for hamming_scrub_ctrl.
package hamming_pkg;

  localparam int CW_W   = 13;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_CORR   = 2'b01,
    ERR_UNCORR = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    IDLE,
    HOST_RD,
    SCRUB
  } state_e;

  // Parity bit 2^k covers every position 1..12 whose index has bit k set.
  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] data);
    logic [CW_W-1:0] cw;
    logic            p;
    cw      = '0;
    cw[3]   = data[0];
    cw[7:5] = data[3:1];
    cw[12:9] = data[7:4];
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int i = 1; i < CW_W; i++) begin
        if (i[k]) p = p ^ cw[i];
      end
      cw[1 << k] = p;
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_secded_dec_13_8.sv
// Combinational (13,8) SECDED decoder: syndrome, overall parity, single-bit repair.
module hamming_secded_dec_13_8
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]   cw,
  output logic [CW_W-1:0]   corr_cw,
  output logic [DATA_W-1:0] data,
  output logic              correctable,
  output logic              uncorrectable
);

  logic [3:0] syndrome;
  logic       overall;

  // NOTE: every output gets a value before any conditional logic, so no latch is inferred.
  always_comb begin
    syndrome = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (cw[i]) syndrome = syndrome ^ i[3:0];
    end
    overall       = ^cw;
    correctable   = overall && (syndrome <= 4'd12);
    uncorrectable = (!overall && (syndrome != 4'd0)) || (overall && (syndrome > 4'd12));
    corr_cw       = correctable ? (cw ^ (CW_W'(1) << syndrome)) : cw;
    data          = {corr_cw[12:9], corr_cw[7:5], corr_cw[3]};
  end

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// SECDED-protected codeword array with host port and background scrubber.
// Optional HAMMING_INJECT_EN: host writes store encode(wdata) XOR inj_mask.
module hamming_scrub_ctrl
  import hamming_pkg::*;
#(
  parameter  int DEPTH          = 16,
  parameter  int SCRUB_INTERVAL = 256,
  localparam int ADDR_W         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  input  logic [12:0]       inj_mask,
  input  logic              scrub_en,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [15:0]       cnt_corr,
  output logic [15:0]       cnt_uncorr
);

  localparam int                 TIMER_W = $clog2(SCRUB_INTERVAL);
  localparam logic [TIMER_W-1:0] RELOAD  = TIMER_W'(SCRUB_INTERVAL - 1);

  state_e              state_q, state_d;
  logic [CW_W-1:0]     mem_q [DEPTH];
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   scrub_ptr_q;
  logic                scrub_pend_q;
  logic [TIMER_W-1:0]  timer_q;

  logic                accept_wr;
  logic                accept_rd;
  logic [ADDR_W-1:0]   dec_addr;
  logic [CW_W-1:0]     dec_corr_cw;
  logic [DATA_W-1:0]   dec_data;
  logic                dec_correctable;
  logic                dec_uncorrectable;
  logic                busy;
  logic [CW_W-1:0]     wr_cw;
  err_e                err_code;

`ifdef HAMMING_INJECT_EN
  assign wr_cw = encode(req_wdata) ^ inj_mask;
`else
  logic unused_inj;
  assign unused_inj = ^inj_mask;
  assign wr_cw      = encode(req_wdata);
`endif

  // One decoder serves both the host read and the scrubber.
  assign busy     = (state_q != IDLE);
  assign dec_addr = (state_q == SCRUB) ? scrub_ptr_q : rd_addr_q;

  hamming_secded_dec_13_8 u_dec (
    .cw            (mem_q[dec_addr]),
    .corr_cw       (dec_corr_cw),
    .data          (dec_data),
    .correctable   (dec_correctable),
    .uncorrectable (dec_uncorrectable)
  );

  always_comb begin
    if (dec_uncorrectable)    err_code = ERR_UNCORR;
    else if (dec_correctable) err_code = ERR_CORR;
    else                      err_code = ERR_NONE;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_write) begin
            accept_wr = 1'b1;
          end else begin
            accept_rd = 1'b1;
            state_d   = HOST_RD;
          end
        end else if (scrub_pend_q) begin
          state_d = SCRUB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the array is reset like any other state because every entry must
  // read back as a valid all-zero codeword after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept_wr) begin
      mem_q[req_addr] <= wr_cw;
    end else if (busy && dec_correctable) begin
      mem_q[dec_addr] <= dec_corr_cw;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      scrub_ptr_q  <= '0;
      scrub_pend_q <= 1'b0;
      timer_q      <= RELOAD;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= ERR_NONE;
      cnt_corr     <= '0;
      cnt_uncorr   <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      if (accept_rd) rd_addr_q <= req_addr;
      if (state_q == HOST_RD) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= dec_data;
        rsp_err   <= err_code;
      end
      if (busy && dec_correctable && (cnt_corr != 16'hFFFF))
        cnt_corr <= cnt_corr + 16'd1;
      if (busy && dec_uncorrectable && (cnt_uncorr != 16'hFFFF))
        cnt_uncorr <= cnt_uncorr + 16'd1;
      if (state_q == SCRUB) scrub_ptr_q <= scrub_ptr_q + ADDR_W'(1);
      if (scrub_en) timer_q <= (timer_q == '0) ? RELOAD : timer_q - TIMER_W'(1);
      // A fresh expiry wins over the clear of the scrub being serviced.
      if (scrub_en && (timer_q == '0)) scrub_pend_q <= 1'b1;
      else if (state_q == SCRUB)       scrub_pend_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Self-checking bench for hamming_scrub_ctrl against an entry-level error model.
module tb_hamming_scrub_ctrl;

  localparam int DEPTH = 16;
  localparam int SI    = 4;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [7:0]    req_wdata = '0;
  logic [12:0]   inj_mask = '0;
  logic          scrub_en = 1'b0;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic [1:0]    rsp_err;
  logic [15:0]   cnt_corr;
  logic [15:0]   cnt_uncorr;

  always #5 clk = ~clk;

  hamming_scrub_ctrl #(.DEPTH(DEPTH), .SCRUB_INTERVAL(SI)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .inj_mask   (inj_mask),
    .scrub_en   (scrub_en),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .cnt_corr   (cnt_corr),
    .cnt_uncorr (cnt_uncorr)
  );

  int checks   = 0;
  int failures = 0;

  // Model: each entry holds its data byte and the number of flipped bits.
  logic [7:0] m_data [DEPTH];
  int         m_errs [DEPTH];
  int         m_corr, m_uncorr, m_ptr;
  int         scrubs_seen = 0;
  bit         rd_busy = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = 8'h00;
      m_errs[i] = 0;
    end
    m_corr = 0;
    m_uncorr = 0;
    m_ptr = 0;
  endtask

  function automatic void model_touch(int a);
    if (m_errs[a] == 1) begin
      m_errs[a] = 0;
      if (m_corr < 65535) m_corr++;
    end else if (m_errs[a] >= 2) begin
      if (m_uncorr < 65535) m_uncorr++;
    end
  endfunction

  function automatic int mask_weight(logic [12:0] m);
`ifdef HAMMING_INJECT_EN
    return $countones(m);
`else
    return (m == 13'h1FFF) ? 1 : 0;
`endif
  endfunction

  function automatic logic [12:0] gen_mask();
    logic [12:0] m;
    int w, b0, b1;
    m  = '0;
    w  = $urandom_range(0, 2);
    b0 = $urandom_range(0, 12);
    if (w >= 1) m[b0] = 1'b1;
    if (w == 2) begin
      b1 = (b0 + $urandom_range(1, 12)) % 13;
      m[b1] = 1'b1;
    end
    return m;
  endfunction

  task automatic fail_line(string name, int act, int req);
    failures++;
    $display("FAIL %s got=0x%0h expected=0x%0h", name, act, req);
  endtask

  // Advance one clock; a not-ready cycle not caused by our read is a scrub.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (!rd_busy && (req_ready === 1'b0)) begin
      scrubs_seen++;
      model_touch(m_ptr);
      m_ptr = (m_ptr + 1) % DEPTH;
    end
  endtask

  task automatic wait_ready(string tag);
    int n = 0;
    while ((req_ready !== 1'b1) && (n < 20)) begin
      cycle();
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      fail_line({tag, "_ready_timeout"}, int'(req_ready), 1);
    end
  endtask

  task automatic do_write(int a, logic [7:0] d, logic [12:0] mask);
    wait_ready("write");
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = AW'(a);
    req_wdata = d;
    inj_mask  = mask;
    m_data[a] = d;
    m_errs[a] = mask_weight(mask);
    cycle();
    req_valid = 1'b0;
    req_write = 1'b0;
    inj_mask  = '0;
  endtask

  task automatic do_read(int a, string tag);
    logic [1:0] exp_err;
    logic [7:0] exp_data;
    wait_ready(tag);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = AW'(a);
    rd_busy   = 1'b1;
    cycle();
    req_valid = 1'b0;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b00)
      fail_line({tag, "_busy_ready_rspvalid"}, int'({req_ready, rsp_valid}), 0);
    rd_busy  = 1'b0;
    exp_data = m_data[a];
    exp_err  = (m_errs[a] == 0) ? 2'b00 : (m_errs[a] == 1) ? 2'b01 : 2'b10;
    model_touch(a);
    cycle();
    checks++;
    if (rsp_valid !== 1'b1) fail_line({tag, "_rsp_valid"}, int'(rsp_valid), 1);
    checks++;
    if (rsp_err !== exp_err) fail_line({tag, "_rsp_err"}, int'(rsp_err), int'(exp_err));
    if (exp_err != 2'b10) begin
      checks++;
      if (rsp_rdata !== exp_data) fail_line({tag, "_rsp_rdata"}, int'(rsp_rdata), int'(exp_data));
    end
    checks++;
    if (cnt_corr !== 16'(m_corr)) fail_line({tag, "_cnt_corr"}, int'(cnt_corr), m_corr);
    checks++;
    if (cnt_uncorr !== 16'(m_uncorr)) fail_line({tag, "_cnt_uncorr"}, int'(cnt_uncorr), m_uncorr);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) fail_line("reset_req_ready", int'(req_ready), 1);
    checks++;
    if (rsp_valid !== 1'b0) fail_line("reset_rsp_valid", int'(rsp_valid), 0);
    checks++;
    if ({rsp_rdata, rsp_err} !== 10'h000) fail_line("reset_rsp_data_err", int'({rsp_rdata, rsp_err}), 0);
    checks++;
    if ({cnt_corr, cnt_uncorr} !== 32'h0) fail_line("reset_counters", int'({cnt_corr, cnt_uncorr}), 0);
    do_read(11, "reset_read");
  endtask

  task automatic test_write_read();
    do_write(3, 8'hA5, 13'h0000);
    do_read(3, "wr_rd_a5");
  endtask

  task automatic test_inject_single();
    do_write(5, 8'h3C, 13'h0040);
    do_read(5, "inj1_first");
    do_read(5, "inj1_reread");
  endtask

  task automatic test_inject_double();
    do_write(7, 8'h81, 13'h0006);
    do_read(7, "inj2_first");
    do_read(7, "inj2_reread");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      int a;
      a = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, 8'($urandom), gen_mask());
        do_read(a, "b2b_wr_then_rd");
      end else begin
        do_read(a, "b2b_rd");
      end
    end
  endtask

  task automatic test_reset_mid_read();
    do_write(9, 8'hC3, 13'h0200);
    wait_ready("rst_mid");
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = AW'(9);
    rd_busy   = 1'b1;
    cycle();
    req_valid = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if (rsp_valid !== 1'b0) fail_line("rst_mid_rsp_valid_in_reset", int'(rsp_valid), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_busy = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (rsp_valid !== 1'b0) fail_line("rst_mid_rsp_valid_after", int'(rsp_valid), 0);
    end
    checks++;
    if ({cnt_corr, cnt_uncorr} !== 32'h0) fail_line("rst_mid_counters", int'({cnt_corr, cnt_uncorr}), 0);
    do_read(9, "rst_mid_reread");
    do_read($urandom_range(0, DEPTH - 1), "rst_mid_any");
  endtask

  // Runs straight after a reset, so the timer and scrub pointer start fresh.
  task automatic test_scrub();
    int first, base;
    do_write(0, 8'h5A, 13'h0100);
    scrub_en = 1'b1;
    base  = scrubs_seen;
    first = -1;
    for (int c = 1; c <= 2 * SI; c++) begin
      cycle();
      if ((first < 0) && (scrubs_seen != base)) first = c;
    end
    checks++;
    if (first != SI + 1) fail_line("scrub_first_cycle", first, SI + 1);
    checks++;
    if (scrubs_seen - base != 1) fail_line("scrub_count_window", scrubs_seen - base, 1);
    checks++;
    if (cnt_corr !== 16'(m_corr)) fail_line("scrub_cnt_corr", int'(cnt_corr), m_corr);
    scrub_en = 1'b0;
    repeat (4) cycle();
    do_read(0, "scrub_read_addr0");
  endtask

  task automatic test_arbitration();
    int base, low, first_low;
    wait_ready("arb");
    scrub_en  = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    for (int c = 0; c < 10; c++) begin
      int a;
      a = $urandom_range(0, DEPTH - 1);
      req_addr  = AW'(a);
      req_wdata = 8'($urandom);
      m_data[a] = req_wdata;
      m_errs[a] = 0;
      cycle();
      checks++;
      if (req_ready !== 1'b1) fail_line("arb_host_holds_ready", int'(req_ready), 1);
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    scrub_en  = 1'b0;
    base = scrubs_seen;
    low  = 0;
    first_low = -1;
    for (int c = 1; c <= 6; c++) begin
      cycle();
      if (req_ready === 1'b0) begin
        low++;
        if (first_low < 0) first_low = c;
      end
    end
    checks++;
    if (low != 1) fail_line("arb_scrub_busy_cycles", low, 1);
    checks++;
    if (first_low != 1) fail_line("arb_scrub_start", first_low, 1);
    checks++;
    if (scrubs_seen - base != 1) fail_line("arb_scrub_events", scrubs_seen - base, 1);
    do_read($urandom_range(0, DEPTH - 1), "arb_after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_inject_single();
    test_inject_double();
    test_back_to_back();
    test_reset_mid_read();
    test_scrub();
    test_arbitration();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
